// File: rtl/multich_decimator.sv
// multich_decimator
//   Decimates CHANNELS parallel signed sample streams by SAMPLE_RATE and
//   presents one packed result word per frame on a valid/ready interface.
//   Runtime modes: pick (first sample of frame), sum, mean (floor of sum/N).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ena           block enable; low freezes frame progress
//   flush         discard the partial frame (phase and accumulators cleared)
//   mode          0=pick, 1=sum, 2=mean, 3=sum; latched at frame start
//   in_valid      data_in holds a sample set
//   data_in       packed signed samples, channel 0 in the LSBs
//   out_valid     dout holds an unconsumed result
//   out_ready     downstream accepts
//   dout          packed signed results, channel 0 in the LSBs
//   overrun       sticky: a completed frame was dropped under backpressure
//   clr_ovr       clear overrun (a coincident drop wins)
//   phase         current frame position (debug)
module multich_decimator #(
    parameter int DATA_WIDTH  = 14,
    parameter int SAMPLE_RATE = 4,
    parameter int CHANNELS    = 2,
    parameter int OUT_WIDTH   = DATA_WIDTH + SAMPLE_RATE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              flush,
    input  logic [1:0]                        mode,
    input  logic                              in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]    data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0]     dout,
    output logic                              overrun,
    input  logic                              clr_ovr,
    output logic [$clog2(SAMPLE_RATE)-1:0]    phase
);

    localparam int PW = $clog2(SAMPLE_RATE);
    localparam logic [PW-1:0] LAST_PHASE = PW'(SAMPLE_RATE - 1);

    typedef enum logic [1:0] {
        MODE_PICK = 2'd0,
        MODE_SUM  = 2'd1,
        MODE_MEAN = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
        return {{(OUT_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    // Arithmetic shift: rounds toward minus infinity.
    function automatic logic signed [OUT_WIDTH-1:0] mean_of(input logic signed [OUT_WIDTH-1:0] s);
        return s >>> PW;
    endfunction

    mode_t                        mode_p0;
    logic signed [OUT_WIDTH-1:0]  acc_p0   [CHANNELS];
    logic signed [DATA_WIDTH-1:0] first_p0 [CHANNELS];
    logic signed [DATA_WIDTH-1:0] samp_raw [CHANNELS];
    logic signed [OUT_WIDTH-1:0]  samp     [CHANNELS];
    logic signed [OUT_WIDTH-1:0]  sum_nx   [CHANNELS];
    logic signed [OUT_WIDTH-1:0]  res      [CHANNELS];

    logic accept, last, load, drop;

    assign accept = in_valid & ena & ~flush;
    assign last   = accept && (phase == LAST_PHASE);
    // A completing frame loads unless an unconsumed word is being held.
    assign load   = last && (!out_valid || out_ready);
    assign drop   = last && out_valid && !out_ready;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            samp_raw[c] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            samp[c]     = sext(samp_raw[c]);
            sum_nx[c]   = acc_p0[c] + samp[c];
            case (mode_p0)
                MODE_PICK: res[c] = sext(first_p0[c]);
                MODE_MEAN: res[c] = mean_of(sum_nx[c]);
                default:   res[c] = sum_nx[c];
            endcase
        end
    end

    // Stage p0: frame accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= '0;
            mode_p0 <= MODE_PICK;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_p0[c]   <= '0;
                first_p0[c] <= '0;
            end
        end else if (flush) begin
            phase <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_p0[c]   <= '0;
                first_p0[c] <= '0;
            end
        end else if (accept) begin
            phase <= phase + 1'b1;
            if (phase == '0) begin
                mode_p0 <= mode_t'(mode);
                for (int c = 0; c < CHANNELS; c++) begin
                    acc_p0[c]   <= samp[c];
                    first_p0[c] <= samp_raw[c];
                end
            end else begin
                for (int c = 0; c < CHANNELS; c++)
                    acc_p0[c] <= sum_nx[c];
            end
        end
    end

    // Stage p1: output register and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                for (int c = 0; c < CHANNELS; c++)
                    dout[c*OUT_WIDTH +: OUT_WIDTH] <= res[c];
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multich_decimator.sv
module tb_multich_decimator;

    localparam int DW = 14;
    localparam int SR = 4;
    localparam int CH = 2;
    localparam int OW = 18;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              flush;
    logic [1:0]        mode;
    logic              in_valid;
    logic [CH*DW-1:0]  data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CH*OW-1:0]  dout;
    logic              overrun;
    logic              clr_ovr;
    logic [1:0]        phase;

    int checks = 0;
    int errors = 0;
    logic [CH*OW-1:0] exp_q[$];

    multich_decimator #(
        .DATA_WIDTH(DW), .SAMPLE_RATE(SR), .CHANNELS(CH), .OUT_WIDTH(OW)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .flush(flush), .mode(mode),
        .in_valid(in_valid), .data_in(data_in), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout), .overrun(overrun),
        .clr_ovr(clr_ovr), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model for one frame of one channel.
    function automatic int calc(int m, int a, int b, int c, int d);
        int s;
        s = a + b + c + d;
        case (m)
            0:       return a;
            2:       return s >>> 2;
            default: return s;
        endcase
    endfunction

    function automatic logic [CH*OW-1:0] pack(int r0, int r1);
        return {r1[OW-1:0], r0[OW-1:0]};
    endfunction

    // Scoreboard: every transfer pops and compares one expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: got dout=%h, required no transfer", dout);
            end else begin
                logic [CH*OW-1:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL scoreboard_dout: got %h, required %h", dout, e);
                end
            end
        end
    end

    task automatic send(int a, int b);
        in_valid = 1'b1;
        data_in  = {b[DW-1:0], a[DW-1:0]};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic frame(int m, int a0, int b0, int c0, int d0,
                         int a1, int b1, int c1, int d1, bit push);
        mode = m[1:0];
        if (push) exp_q.push_back(pack(calc(m, a0, b0, c0, d0), calc(m, a1, b1, c1, d1)));
        send(a0, a1); send(b0, b1); send(c0, c1); send(d0, d1);
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; flush = 1'b0; mode = 2'd1; in_valid = 1'b0;
        data_in = '0; out_ready = 1'b1; clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h, required 0", dout); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase: got %0d, required 0", phase); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sum();
        out_ready = 1'b1;
        frame(1, 1, 2, 3, 4, -1, -2, -3, -4, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sum_valid_latency: got %b, required 1", out_valid); end
        checks++; if (dout[2*OW-1:OW] !== 18'h3FFF6) begin errors++; $display("FAIL sum_ch1: got %h, required 3fff6", dout[2*OW-1:OW]); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sum_valid_pulse: got %b, required 0", out_valid); end
    endtask

    task automatic test_mean();
        out_ready = 1'b1;
        frame(2, 8191, 8191, 8191, 8191, -8192, -8192, -8192, -8192, 1'b1);
        @(posedge clk); #1;
        frame(2, 1, 1, 1, 2, -1, -1, -1, -2, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_pick_mode_change();
        out_ready = 1'b1;
        mode = 2'd0;
        exp_q.push_back(pack(5, -5));
        send(5, -5); send(6, -6);
        mode = 2'd1;
        send(7, -7); send(8, -8);
        @(posedge clk); #1;
        frame(1, 1, 1, 1, 1, 3, 3, 3, 3, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [CH*OW-1:0] first_word;
        out_ready = 1'b0;
        frame(1, 1, 2, 3, 4, 0, 0, 0, 1, 1'b1);
        first_word = pack(10, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b, required 1", out_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun_yet: got %b, required 0", overrun); end
        frame(1, 5, 5, 5, 5, 2, 2, 2, 2, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b, required 1", overrun); end
        checks++; if (dout !== first_word) begin errors++; $display("FAIL bp_dout_stable: got %h, required %h", dout, first_word); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got %b, required 0", out_valid); end
        clr_ovr = 1'b1;
        @(posedge clk); #1;
        clr_ovr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clr_ovr: got %b, required 0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [CH*OW-1:0] second_word;
        out_ready = 1'b0;
        frame(1, 1, 1, 1, 1, 2, 2, 2, 2, 1'b1);
        mode = 2'd1;
        second_word = pack(calc(1, 3, 4, 5, 6), calc(1, -7, -7, -7, -7));
        exp_q.push_back(second_word);
        send(3, -7); send(4, -7); send(5, -7);
        out_ready = 1'b1;
        send(6, -7);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_stays: got %b, required 1", out_valid); end
        checks++; if (dout !== second_word) begin errors++; $display("FAIL b2b_new_word: got %h, required %h", dout, second_word); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b, required 0", overrun); end
        @(posedge clk); #1;
    endtask

    task automatic test_gaps_flush();
        out_ready = 1'b1;
        mode = 2'd1;
        exp_q.push_back(pack(10, -10));
        send(1, -1);
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL gap_phase_adv: got %0d, required 1", phase); end
        @(posedge clk); #1;
        ena = 1'b0; in_valid = 1'b1; data_in = {14'h1555, 14'h0AAA};
        @(posedge clk); #1;
        in_valid = 1'b0; ena = 1'b1;
        checks++; if (phase !== 2'd1) begin errors++; $display("FAIL gap_phase_hold: got %0d, required 1", phase); end
        send(2, -2);
        @(posedge clk); #1;
        send(3, -3);
        ena = 1'b0; in_valid = 1'b1; data_in = {14'h0123, 14'h0321};
        @(posedge clk); #1;
        in_valid = 1'b0; ena = 1'b1;
        send(4, -4);
        @(posedge clk); #1;

        send(9, 9); send(9, 9);
        flush = 1'b1; in_valid = 1'b1; data_in = {14'd100, 14'd100};
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL flush_phase: got %0d, required 0", phase); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_output: got %b, required 0", out_valid); end
        frame(1, 4, 4, 4, 4, -4, -4, -4, -4, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b0;
        frame(1, 1, 1, 1, 1, 1, 1, 1, 1, 1'b0);
        frame(1, 5, 5, 5, 5, 5, 5, 5, 5, 1'b0);
        send(7, 7); send(7, 7);
        checks++; if (phase !== 2'd2) begin errors++; $display("FAIL rst_pre_phase: got %0d, required 2", phase); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b, required 0", out_valid); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_async_dout: got %h, required 0", dout); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_async_overrun: got %b, required 0", overrun); end
        checks++; if (phase !== 2'd0) begin errors++; $display("FAIL rst_async_phase: got %0d, required 0", phase); end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        frame(1, 2, 2, 2, 2, -2, -2, -2, -2, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sum();
        test_mean();
        test_pick_mode_change();
        test_backpressure();
        test_back_to_back();
        test_gaps_flush();
        test_reset_mid_frame();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
